fwd_hazard_ctrl: RTL

Forwarding and hazard scheduler for the five-stage pipeline. It tracks the destination registers of the instructions in EX and MEM and produces the registered `ALUREDI`/`SYSREDI` select codes that steer the ALU stage operand and syscall-argument muxes onto the `R` (EX/MEM result) or `WB` (writeback) bypasses. It raises a one-cycle stall on load-use hazards, inserts bubbles on stall and flush, and freezes while the syscall unit holds `lock`. It sits beside the ID/EX pipeline register and feeds the ALU-stage wrapper directly.

---
 rtl/fwd_hazard_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: ALU/syscall bypass selects, load-use stall, bubble insertion.
// Optional define FWD_SYS_EN: forward syscall arguments v0/a0 instead of stalling.
module fwd_hazard_ctrl #(
    parameter int REG_AW = 5
) (
    input  logic              in_CLK,
    input  logic              in_RST,
    input  logic [REG_AW-1:0] in_ID_rs,
    input  logic [REG_AW-1:0] in_ID_rt,
    input  logic              in_ID_use_rs,
    input  logic              in_ID_use_rt,
    input  logic              in_ID_wr,
    input  logic [REG_AW-1:0] in_ID_dst,
    input  logic              in_ID_load,
    input  logic              in_ID_syscall,
    input  logic              in_flush,
    input  logic              in_lock,
    output logic [3:0]        out_ALUREDI,
    output logic [3:0]        out_SYSREDI,
    output logic              out_stall,
    output logic              out_bubble
);

    localparam logic [REG_AW-1:0] REG_V0 = REG_AW'(2);
    localparam logic [REG_AW-1:0] REG_A0 = REG_AW'(4);

    logic              ex_vld;
    logic [REG_AW-1:0] ex_dst;
    logic              ex_load;
    logic              mem_vld;
    logic [REG_AW-1:0] mem_dst;

    logic [1:0] x_code;
    logic [1:0] y_code;
    logic [1:0] v0_code;
    logic [1:0] a0_code;
    logic [3:0] alu_sel;
    logic [3:0] sys_sel;
    logic       ld_tag;
    logic       load_use;
    logic       sys_hold;
    logic       hazard;

    // Returns {wb, r}: EX (newest writer) wins over MEM; $0 never forwards.
    function automatic logic [1:0] fwd_code(
        input logic              use_src,
        input logic [REG_AW-1:0] src,
        input logic              ev,
        input logic [REG_AW-1:0] ed,
        input logic              mv,
        input logic [REG_AW-1:0] md
    );
        logic nz;
        logic hit_ex;
        logic hit_mem;
        nz      = (src != '0);
        hit_ex  = ev && (ed == src) && nz;
        hit_mem = mv && (md == src) && nz;
        return {use_src && !hit_ex && hit_mem, use_src && hit_ex};
    endfunction

    // Bypass codes for the ID operands and the implicit syscall arguments.
    always_comb begin
        x_code  = fwd_code(in_ID_use_rs, in_ID_rs,
                           ex_vld, ex_dst, mem_vld, mem_dst);
        y_code  = fwd_code(in_ID_use_rt, in_ID_rt,
                           ex_vld, ex_dst, mem_vld, mem_dst);
        v0_code = fwd_code(in_ID_syscall, REG_V0,
                           ex_vld, ex_dst, mem_vld, mem_dst);
        a0_code = fwd_code(in_ID_syscall, REG_A0,
                           ex_vld, ex_dst, mem_vld, mem_dst);
        alu_sel = {y_code[1], x_code[1], y_code[0], x_code[0]};
`ifdef FWD_SYS_EN
        sys_sel  = {a0_code[1], v0_code[1], a0_code[0], v0_code[0]};
        sys_hold = 1'b0;
`else
        sys_sel  = 4'b0000;
        sys_hold = (|v0_code) || (|a0_code);
`endif
    end

    // Load result only exists at WB, so a consumer right behind it must wait.
    always_comb begin
        ld_tag   = ex_vld && ex_load && (ex_dst != '0);
        load_use = ld_tag && (
                     (in_ID_use_rs && (in_ID_rs == ex_dst)) ||
                     (in_ID_use_rt && (in_ID_rt == ex_dst)) ||
                     (in_ID_syscall &&
                      ((ex_dst == REG_V0) || (ex_dst == REG_A0))));
        hazard    = load_use || sys_hold;
        out_stall = in_lock || hazard;
    end

    // Advance tags and register selects; lock freezes everything.
    always_ff @(posedge in_CLK) begin
        if (in_RST) begin
            ex_vld      <= 1'b0;
            ex_dst      <= '0;
            ex_load     <= 1'b0;
            mem_vld     <= 1'b0;
            mem_dst     <= '0;
            out_ALUREDI <= 4'b0000;
            out_SYSREDI <= 4'b0000;
            out_bubble  <= 1'b1;
        end else if (!in_lock) begin
            mem_vld <= ex_vld;
            mem_dst <= ex_dst;
            if (hazard || in_flush) begin
                ex_vld      <= 1'b0;
                ex_dst      <= '0;
                ex_load     <= 1'b0;
                out_ALUREDI <= 4'b0000;
                out_SYSREDI <= 4'b0000;
                out_bubble  <= 1'b1;
            end else begin
                ex_vld      <= in_ID_wr;
                ex_dst      <= in_ID_dst;
                ex_load     <= in_ID_load;
                out_ALUREDI <= alu_sel;
                out_SYSREDI <= sys_sel;
                out_bubble  <= 1'b0;
            end
        end
    end

endmodule
